// File: rtl/axil_ad_ctrl.sv
// AXI4-Lite register block that enables, counts and snoops two AD stream sinks.
// The write and read channels are independent two-state FSMs.
module axil_ad_ctrl #(
  parameter int          ADDR_W   = 8,
  parameter int          AD_DW    = 32,
  parameter logic [31:0] ID_VAL   = 32'hAD0C_0001,
  parameter logic [1:0]  CTRL_RST = 2'b00
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] axi_awaddr,
  input  logic              axi_awvalid,
  output logic              axi_awready,
  input  logic [31:0]       axi_wdata,
  input  logic [3:0]        axi_wstrb,
  input  logic              axi_wvalid,
  output logic              axi_wready,
  output logic [1:0]        axi_bresp,
  output logic              axi_bvalid,
  input  logic              axi_bready,
  input  logic [ADDR_W-1:0] axi_araddr,
  input  logic              axi_arvalid,
  output logic              axi_arready,
  output logic [31:0]       axi_rdata,
  output logic [1:0]        axi_rresp,
  output logic              axi_rvalid,
  input  logic              axi_rready,
  input  logic              ad0_tvalid,
  input  logic [AD_DW-1:0]  ad0_tdata,
  output logic              ad0_tready,
  input  logic              ad1_tvalid,
  input  logic [AD_DW-1:0]  ad1_tdata,
  output logic              ad1_tready
);

  typedef enum logic {W_ADDR_DATA, W_RESP} w_state_t;
  typedef enum logic {R_ADDR, R_DATA} r_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic             aw_held, w_held;
  logic [2:0]       aw_idx_q;
  logic [1:0]       w_en_q, w_strb_q;
  logic             w_clr_q;
  logic             aw_hs, w_hs, wr_go, wr_ctrl, clr_cnt, ar_hs;
  logic [2:0]       wr_idx;
  logic [1:0]       wr_en_bits, wr_strb;
  logic             wr_clr;
  logic [1:0]       ctrl_en;
  logic             tready0, tready1, acc0, acc1;
  logic [31:0]      cnt0, cnt1;
  logic [AD_DW-1:0] last0, last1;
  logic [31:0]      rd_data;
  logic [1:0]       rd_resp;
  logic             unused;

  assign unused = ^{axi_awaddr[ADDR_W-1:5], axi_awaddr[1:0], axi_araddr[ADDR_W-1:5],
                    axi_araddr[1:0], axi_wdata[31:9], axi_wdata[7:2], axi_wstrb[3:2]};

  // Write channel: AW and W may arrive in either order; a captured half is
  // merged with the live half so the write fires on the edge both are present.
  assign aw_hs      = axi_awvalid & axi_awready;
  assign w_hs       = axi_wvalid & axi_wready;
  assign wr_go      = (w_state == W_ADDR_DATA) && (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_idx     = aw_held ? aw_idx_q : axi_awaddr[4:2];
  assign wr_en_bits = w_held ? w_en_q : axi_wdata[1:0];
  assign wr_clr     = w_held ? w_clr_q : axi_wdata[8];
  assign wr_strb    = w_held ? w_strb_q : axi_wstrb[1:0];
  assign wr_ctrl    = wr_go && (wr_idx == 3'd0);
  assign clr_cnt    = wr_ctrl && wr_strb[1] && wr_clr;

  always_ff @(posedge clock) begin
    if (reset) w_state <= W_ADDR_DATA;
    else       w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_ADDR_DATA: if (wr_go) w_next = W_RESP;
      W_RESP:      if (axi_bready) w_next = W_ADDR_DATA;
      default:     w_next = W_ADDR_DATA;
    endcase
  end

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    axi_awready = 1'b0;
    axi_wready  = 1'b0;
    axi_bvalid  = 1'b0;
    case (w_state)
      W_ADDR_DATA: begin
        axi_awready = !aw_held;
        axi_wready  = !w_held;
      end
      W_RESP:  axi_bvalid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      axi_bresp <= RESP_OKAY;
    end else if (wr_go) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      axi_bresp <= (wr_idx == 3'd0) ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs) aw_held <= 1'b1;
      if (w_hs)  w_held  <= 1'b1;
    end
  end

  // NOTE: payload registers are only read while their held flag is set, so they need no reset.
  always_ff @(posedge clock) begin
    if (aw_hs) aw_idx_q <= axi_awaddr[4:2];
    if (w_hs) begin
      w_en_q   <= axi_wdata[1:0];
      w_clr_q  <= axi_wdata[8];
      w_strb_q <= axi_wstrb[1:0];
    end
  end

  // Control, stream gating and per-channel monitors; a clear beats a same-cycle beat.
  assign acc0       = ad0_tvalid & tready0;
  assign acc1       = ad1_tvalid & tready1;
  assign ad0_tready = tready0;
  assign ad1_tready = tready1;

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_en <= CTRL_RST;
      tready0 <= 1'b0;
      tready1 <= 1'b0;
      cnt0    <= '0;
      cnt1    <= '0;
      last0   <= '0;
      last1   <= '0;
    end else begin
      if (wr_ctrl && wr_strb[0]) ctrl_en <= wr_en_bits;
      tready0 <= ctrl_en[0];
      tready1 <= ctrl_en[1];
      if (clr_cnt) begin
        cnt0  <= '0;
        cnt1  <= '0;
        last0 <= '0;
        last1 <= '0;
      end else begin
        if (acc0) begin
          cnt0  <= cnt0 + 32'd1;
          last0 <= ad0_tdata;
        end
        if (acc1) begin
          cnt1  <= cnt1 + 32'd1;
          last1 <= ad1_tdata;
        end
      end
    end
  end

  // Read channel
  assign ar_hs = axi_arvalid & axi_arready;

  always_ff @(posedge clock) begin
    if (reset) r_state <= R_ADDR;
    else       r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_ADDR:  if (axi_arvalid) r_next = R_DATA;
      R_DATA:  if (axi_rready) r_next = R_ADDR;
      default: r_next = R_ADDR;
    endcase
  end

  always_comb begin
    axi_arready = (r_state == R_ADDR);
    axi_rvalid  = (r_state == R_DATA);
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (axi_araddr[4:2])
      3'd0:    rd_data = {30'd0, ctrl_en};
      3'd1:    rd_data = {28'd0, tready1, tready0, ad1_tvalid, ad0_tvalid};
      3'd2:    rd_data = cnt0;
      3'd3:    rd_data = cnt1;
      3'd4:    rd_data = 32'(last0);
      3'd5:    rd_data = 32'(last1);
      3'd6:    rd_data = ID_VAL;
      default: rd_resp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      axi_rdata <= '0;
      axi_rresp <= RESP_OKAY;
    end else if (ar_hs) begin
      axi_rdata <= rd_data;
      axi_rresp <= rd_resp;
    end
  end

endmodule

// File: tb/tb_axil_ad_ctrl.sv
// Self-checking bench for axil_ad_ctrl: scenario tasks plus a randomized run
// compared against a register-level model of the block.
module tb_axil_ad_ctrl;

  localparam logic [31:0] ID_VAL   = 32'hAD0C_0001;
  localparam logic [1:0]  CTRL_RST = 2'b00;

  logic        clock, reset;
  logic [7:0]  axi_awaddr, axi_araddr;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic [31:0] axi_wdata, axi_rdata;
  logic [3:0]  axi_wstrb;
  logic [1:0]  axi_bresp, axi_rresp;
  logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic        ad0_tvalid, ad0_tready, ad1_tvalid, ad1_tready;
  logic [31:0] ad0_tdata, ad1_tdata;

  int checks = 0;
  int errors = 0;

  // Register-level model of the software-visible state
  logic [1:0]  m_ctrl;
  logic [31:0] m_cnt  [2];
  logic [31:0] m_last [2];

  axil_ad_ctrl #(.ADDR_W(8), .AD_DW(32), .ID_VAL(ID_VAL), .CTRL_RST(CTRL_RST)) dut (
    .clock(clock), .reset(reset),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .ad0_tvalid(ad0_tvalid), .ad0_tdata(ad0_tdata), .ad0_tready(ad0_tready),
    .ad1_tvalid(ad1_tvalid), .ad1_tdata(ad1_tdata), .ad1_tready(ad1_tready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_rdata(input logic [7:0] addr);
    case (addr & 8'h1C)
      8'h00:   return {30'd0, m_ctrl};
      8'h04:   return {28'd0, m_ctrl[1], m_ctrl[0], ad1_tvalid, ad0_tvalid};
      8'h08:   return m_cnt[0];
      8'h0C:   return m_cnt[1];
      8'h10:   return m_last[0];
      8'h14:   return m_last[1];
      8'h18:   return ID_VAL;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [1:0] exp_rresp(input logic [7:0] addr);
    return ((addr & 8'h1C) == 8'h1C) ? 2'b10 : 2'b00;
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < 2; c++) begin
      m_cnt[c]  = 32'd0;
      m_last[c] = 32'd0;
    end
  endfunction

  // Bus drivers; each starts and ends on a falling edge.
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int skew, output logic [1:0] resp, output int lat);
    int  cyc;
    bit  aw_done, w_done;
    aw_done = 0; w_done = 0; cyc = 0;
    axi_awaddr = addr; axi_wdata = data; axi_wstrb = strb;
    while (!(aw_done && w_done) && cyc < 20) begin
      axi_awvalid = !aw_done && (cyc >= -skew);
      axi_wvalid  = !w_done && (cyc >= skew);
      #1;
      if (axi_awvalid && axi_awready) aw_done = 1;
      if (axi_wvalid && axi_wready) w_done = 1;
      @(negedge clock);
      cyc++;
    end
    axi_awvalid = 0; axi_wvalid = 0;
    lat = 0;
    while (axi_bvalid !== 1'b1 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    checks++;
    if (axi_bvalid !== 1'b1) begin
      errors++;
      $display("FAIL write_bvalid_timeout: addr=%h bvalid=%b required 1", addr, axi_bvalid);
    end
    resp = axi_bresp;
    axi_bready = 1; @(negedge clock); axi_bready = 0;
  endtask

  task automatic axi_read(input logic [7:0] addr, input int hold,
                          output logic [31:0] data, output logic [1:0] resp);
    int cyc;
    cyc = 0;
    axi_araddr = addr; axi_arvalid = 1;
    #1;
    while (axi_arready !== 1'b1 && cyc < 20) begin
      @(negedge clock); #1;
      cyc++;
    end
    @(negedge clock);
    axi_arvalid = 0;
    cyc = 0;
    while (axi_rvalid !== 1'b1 && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    checks++;
    if (axi_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL read_rvalid_timeout: addr=%h rvalid=%b required 1", addr, axi_rvalid);
    end
    data = axi_rdata; resp = axi_rresp;
    repeat (hold) @(negedge clock);
    axi_rready = 1; @(negedge clock); axi_rready = 0;
  endtask

  task automatic read_check(input string name, input logic [7:0] addr);
    logic [31:0] d, e;
    logic [1:0]  r;
    e = exp_rdata(addr);
    axi_read(addr, $urandom_range(0, 2), d, r);
    checks++;
    if (d !== e || r !== exp_rresp(addr)) begin
      errors++;
      $display("FAIL %s: addr=%h got data=%h resp=%b required data=%h resp=%b",
               name, addr, d, r, e, exp_rresp(addr));
    end
  endtask

  // A beat is accepted exactly when its channel is enabled.
  task automatic send_beats(input int ch, input int n, input logic [31:0] base, input int max_gap);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      d = base + 32'(i);
      if (ch == 0) begin ad0_tvalid = 1; ad0_tdata = d; end
      else         begin ad1_tvalid = 1; ad1_tdata = d; end
      if (m_ctrl[ch]) begin
        m_cnt[ch]  = m_cnt[ch] + 32'd1;
        m_last[ch] = d;
      end
      @(negedge clock);
      ad0_tvalid = 0; ad1_tvalid = 0;
      repeat ($urandom_range(0, max_gap)) @(negedge clock);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    reset = 1;
    repeat (3) @(negedge clock);
    checks++;
    if ({axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid, ad1_tready, ad0_tready} !== 7'b1110000
        || axi_bresp !== 2'b00 || axi_rresp !== 2'b00 || axi_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: aw/w/ar_ready=%b%b%b bvalid=%b rvalid=%b tready=%b%b bresp=%b rresp=%b rdata=%h required 111 0 0 00 00 00 0",
               axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid, ad1_tready, ad0_tready,
               axi_bresp, axi_rresp, axi_rdata);
    end
    reset = 0;
    m_ctrl = CTRL_RST;
    model_clear();
    @(negedge clock);
    axi_read(8'h18, 0, d, r);
    checks++;
    if (d !== 32'hAD0C0001 || r !== 2'b00) begin
      errors++;
      $display("FAIL reset_id: got %h/%b required AD0C0001/00", d, r);
    end
    read_check("reset_ctrl", 8'h00);
    checks++;
    if ({ad1_tready, ad0_tready} !== CTRL_RST) begin
      errors++;
      $display("FAIL reset_tready: got %b%b required %b", ad1_tready, ad0_tready, CTRL_RST);
    end
  endtask

  task automatic test_write_ctrl();
    logic [1:0] r;
    int lat;
    axi_write(8'h00, 32'h1, 4'hF, 1, r, lat);
    m_ctrl = 2'b01;
    checks++;
    if (r !== 2'b00 || lat !== 0 || axi_bvalid !== 1'b0) begin
      errors++;
      $display("FAIL ctrl_write_resp: bresp=%b lat=%0d bvalid_after=%b required 00 0 0", r, lat, axi_bvalid);
    end
    checks++;
    if ({ad1_tready, ad0_tready} !== 2'b01) begin
      errors++;
      $display("FAIL ctrl_write_tready: got %b%b required 01", ad1_tready, ad0_tready);
    end
    send_beats(0, 5, 32'h10, 0);
    read_check("cnt0_after_5", 8'h08);
    read_check("last0_after_5", 8'h10);
    read_check("cnt1_idle", 8'h0C);
  endtask

  task automatic test_slverr();
    logic [1:0] r;
    int lat;
    axi_write(8'h08, 32'hDEAD_BEEF, 4'hF, 0, r, lat);
    checks++;
    if (r !== 2'b10) begin
      errors++;
      $display("FAIL ro_write_bresp: got %b required 10", r);
    end
    read_check("cnt0_after_ro_write", 8'h08);
    read_check("unmapped_read", 8'h1C);
    axi_write(8'h1C, 32'h3, 4'hF, -1, r, lat);
    checks++;
    if (r !== 2'b10) begin
      errors++;
      $display("FAIL unmapped_write_bresp: got %b required 10", r);
    end
    read_check("ctrl_after_bad_writes", 8'h00);
  endtask

  task automatic test_holds();
    axi_araddr = 8'h18; axi_arvalid = 1;
    #1;
    checks++;
    if (axi_arready !== 1'b1) begin
      errors++;
      $display("FAIL arready_idle: got %b required 1", axi_arready);
    end
    @(negedge clock);
    axi_araddr = 8'h00;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({axi_rvalid, axi_arready, axi_rresp, axi_rdata} !== {1'b1, 1'b0, 2'b00, ID_VAL}) begin
        errors++;
        $display("FAIL rready_hold_%0d: rvalid=%b arready=%b rresp=%b rdata=%h required 1 0 00 %h",
                 i, axi_rvalid, axi_arready, axi_rresp, axi_rdata, ID_VAL);
      end
      @(negedge clock);
    end
    axi_arvalid = 0; axi_rready = 1;
    @(negedge clock);
    axi_rready = 0;
    checks++;
    if ({axi_rvalid, axi_arready} !== 2'b01) begin
      errors++;
      $display("FAIL read_release: rvalid=%b arready=%b required 0 1", axi_rvalid, axi_arready);
    end
    axi_awaddr = 8'h00; axi_wdata = 32'h3; axi_wstrb = 4'h1;
    axi_awvalid = 1; axi_wvalid = 1;
    @(negedge clock);
    m_ctrl = 2'b11;
    axi_wvalid = 0; axi_awaddr = 8'h04;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({axi_bvalid, axi_bresp, axi_awready, axi_wready} !== 5'b1_00_00) begin
        errors++;
        $display("FAIL bready_hold_%0d: bvalid=%b bresp=%b awready=%b wready=%b required 1 00 0 0",
                 i, axi_bvalid, axi_bresp, axi_awready, axi_wready);
      end
      @(negedge clock);
    end
    axi_bready = 1;
    @(negedge clock);
    axi_bready = 0;
    checks++;
    if ({axi_bvalid, axi_awready} !== 2'b01) begin
      errors++;
      $display("FAIL write_release: bvalid=%b awready=%b required 0 1", axi_bvalid, axi_awready);
    end
    axi_wvalid = 1; axi_wdata = 32'h0;
    @(negedge clock);
    axi_awvalid = 0; axi_wvalid = 0;
    checks++;
    if ({axi_bvalid, axi_bresp} !== 3'b1_10) begin
      errors++;
      $display("FAIL queued_aw_resp: bvalid=%b bresp=%b required 1 10", axi_bvalid, axi_bresp);
    end
    axi_bready = 1; @(negedge clock); axi_bready = 0;
    checks++;
    if ({ad1_tready, ad0_tready} !== m_ctrl) begin
      errors++;
      $display("FAIL tready_both: got %b%b required %b", ad1_tready, ad0_tready, m_ctrl);
    end
  endtask

  task automatic test_disable_lag();
    logic [31:0] d;
    d = $urandom;
    ad0_tvalid = 1; ad0_tdata = d;
    axi_awaddr = 8'h00; axi_wdata = 32'h2; axi_wstrb = 4'h1;
    axi_awvalid = 1; axi_wvalid = 1; axi_bready = 1;
    @(negedge clock);
    axi_awvalid = 0; axi_wvalid = 0;
    checks++;
    if (ad0_tready !== 1'b1) begin
      errors++;
      $display("FAIL disable_lag_still_ready: got %b required 1", ad0_tready);
    end
    ad0_tdata = d + 32'd1;
    @(negedge clock);
    checks++;
    if (ad0_tready !== 1'b0) begin
      errors++;
      $display("FAIL disable_lag_dropped: got %b required 0", ad0_tready);
    end
    ad0_tdata = d + 32'd2;
    @(negedge clock);
    ad0_tvalid = 0; axi_bready = 0;
    m_ctrl = 2'b10;
    m_cnt[0]  = m_cnt[0] + 32'd2;
    m_last[0] = d + 32'd1;
    read_check("cnt0_disable_lag", 8'h08);
    read_check("last0_disable_lag", 8'h10);
  endtask

  task automatic test_wrap_clear();
    @(negedge clock);
    force dut.cnt1 = 32'hFFFF_FFFE;
    #1;
    release dut.cnt1;
    m_cnt[1] = 32'hFFFF_FFFE;
    @(negedge clock);
    send_beats(1, 3, $urandom, 1);
    read_check("cnt1_wrap", 8'h0C);
    ad1_tvalid = 1; ad1_tdata = $urandom;
    axi_awaddr = 8'h00; axi_wdata = 32'h102; axi_wstrb = 4'h3;
    axi_awvalid = 1; axi_wvalid = 1; axi_bready = 1;
    @(negedge clock);
    ad1_tvalid = 0; axi_awvalid = 0; axi_wvalid = 0;
    @(negedge clock);
    axi_bready = 0;
    model_clear();
    read_check("cnt1_clear_beat", 8'h0C);
    read_check("last1_clear_beat", 8'h14);
    read_check("cnt0_clear", 8'h08);
    read_check("ctrl_clr_reads_0", 8'h00);
  endtask

  task automatic test_read_during_write();
    logic [31:0] pre;
    send_beats(1, 4, $urandom, 1);
    pre = m_cnt[1];
    axi_araddr = 8'h0C; axi_arvalid = 1; axi_rready = 1;
    axi_awaddr = 8'h00; axi_wdata = 32'h102; axi_wstrb = 4'h3;
    axi_awvalid = 1; axi_wvalid = 1; axi_bready = 1;
    @(negedge clock);
    axi_arvalid = 0; axi_awvalid = 0; axi_wvalid = 0;
    checks++;
    if ({axi_rvalid, axi_bvalid, axi_rdata} !== {1'b1, 1'b1, pre}) begin
      errors++;
      $display("FAIL read_pre_write: rvalid=%b bvalid=%b rdata=%h required 1 1 %h",
               axi_rvalid, axi_bvalid, axi_rdata, pre);
    end
    @(negedge clock);
    axi_rready = 0; axi_bready = 0;
    model_clear();
    read_check("cnt1_post_clear", 8'h0C);
  endtask

  task automatic test_status();
    ad0_tvalid = 1;
    @(negedge clock);
    read_check("status_live", 8'h04);
    ad0_tvalid = 0;
    read_check("cnt0_status_no_beat", 8'h08);
  endtask

  task automatic test_random();
    logic [31:0] data;
    logic [3:0]  strb;
    logic [7:0]  addr;
    logic [1:0]  r;
    int lat, skew;
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          data = $urandom;
          strb = 4'($urandom);
          if ($urandom_range(0, 3) != 0) data[8] = 1'b0;
          skew = $urandom_range(0, 4) - 2;
          addr = {3'($urandom), 3'd0, 2'($urandom)};
          axi_write(addr, data, strb, skew, r, lat);
          if (strb[0]) m_ctrl = data[1:0];
          if (strb[1] && data[8]) model_clear();
          checks++;
          if (r !== 2'b00 || lat !== 0) begin
            errors++;
            $display("FAIL rand_ctrl_write it=%0d: bresp=%b lat=%0d required 00 0", it, r, lat);
          end
        end
        1: send_beats($urandom_range(0, 1), $urandom_range(1, 6), $urandom, 2);
        2: read_check("rand_read", {3'($urandom), 3'($urandom), 2'($urandom)});
        default: begin
          addr = {3'($urandom), 3'($urandom_range(1, 7)), 2'($urandom)};
          axi_write(addr, $urandom, 4'($urandom), $urandom_range(0, 4) - 2, r, lat);
          checks++;
          if (r !== 2'b10) begin
            errors++;
            $display("FAIL rand_ro_write it=%0d addr=%h: bresp=%b required 10", it, addr, r);
          end
        end
      endcase
    end
    for (int a = 0; a < 8; a++) read_check("rand_final", 8'(a * 4));
  endtask

  task automatic test_reset_mid();
    logic [1:0] r;
    int lat;
    axi_awaddr = 8'h00; axi_wdata = 32'h3; axi_wstrb = 4'h1;
    axi_awvalid = 1; axi_wvalid = 1;
    axi_araddr = 8'h18; axi_arvalid = 1;
    @(negedge clock);
    axi_awvalid = 0; axi_wvalid = 0; axi_arvalid = 0;
    checks++;
    if ({axi_bvalid, axi_rvalid} !== 2'b11) begin
      errors++;
      $display("FAIL mid_pending: bvalid=%b rvalid=%b required 1 1", axi_bvalid, axi_rvalid);
    end
    reset = 1;
    @(negedge clock);
    checks++;
    if ({axi_bvalid, axi_rvalid, axi_awready, axi_wready, axi_arready, ad1_tready, ad0_tready} !== 7'b0011100) begin
      errors++;
      $display("FAIL mid_reset_drop: bvalid=%b rvalid=%b aw/w/ar_ready=%b%b%b tready=%b%b required 0 0 111 00",
               axi_bvalid, axi_rvalid, axi_awready, axi_wready, axi_arready, ad1_tready, ad0_tready);
    end
    reset = 0;
    m_ctrl = CTRL_RST;
    model_clear();
    @(negedge clock);
    read_check("mid_ctrl_reset", 8'h00);
    read_check("mid_cnt0_reset", 8'h08);
    axi_write(8'h00, 32'h1, 4'hF, 0, r, lat);
    m_ctrl = 2'b01;
    checks++;
    if (r !== 2'b00 || ad0_tready !== 1'b1) begin
      errors++;
      $display("FAIL mid_recover_write: bresp=%b ad0_tready=%b required 00 1", r, ad0_tready);
    end
    read_check("mid_ctrl_after", 8'h00);
  endtask

  initial begin
    reset = 1;
    axi_awaddr = '0; axi_awvalid = 0; axi_wdata = '0; axi_wstrb = '0; axi_wvalid = 0;
    axi_bready = 0; axi_araddr = '0; axi_arvalid = 0; axi_rready = 0;
    ad0_tvalid = 0; ad0_tdata = '0; ad1_tvalid = 0; ad1_tdata = '0;
    m_ctrl = CTRL_RST;
    model_clear();
    @(negedge clock);
    test_reset();
    test_write_ctrl();
    test_slverr();
    test_holds();
    test_disable_lag();
    test_wrap_clear();
    test_read_during_write();
    test_status();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
